// File: rtl/zmem_stall.sv
// Z80 memory-cycle responder: turns each Z80 MREQ read/write into one DRAM arbiter
// request, stalls the Z80 clock until it is served, and applies turbo only in refresh.
module zmem_stall #(
    parameter int WDOG_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        zpos,
    input  logic        zneg,
    input  logic        mreq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] za,
    input  logic [7:0]  zd_in,
    input  logic [1:0]  turbo_req,
    output logic [1:0]  turbo,
    output logic        cpu_req,
    output logic        cpu_rnw,
    output logic [15:0] cpu_addr,
    output logic [7:0]  cpu_wdata,
    input  logic        cpu_next,
    input  logic        cpu_strobe,
    input  logic [7:0]  dram_rdata,
    output logic [7:0]  zd_out,
    output logic        zd_ena,
    output logic        cpu_stall,
    output logic        wdog_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RDWAIT,
        HOLD
    } state_t;

    // Expiry fires on the edge where the counter would reach all-ones,
    // so a stall lasts at most 2^WDOG_W-1 clocks.
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    state_t            state;
    state_t            state_next;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              armed;
    logic              mem_start;
    logic              stalled;
    logic              wdog_hit;
    logic              latch_req;
    logic              take_data;
    logic              wdog_fire;
    logic              zneg_unused;

    assign zneg_unused = zneg;

    assign stalled   = (state == REQ) || (state == RDWAIT);
    assign cpu_req   = (state == REQ);
    assign cpu_stall = stalled;
    assign mem_start = armed && !mreq_n && rfsh_n && (!rd_n || !wr_n);
    assign wdog_hit  = stalled && (wdog_cnt == WDOG_LAST);

    always_comb begin
        state_next = state;
        latch_req  = 1'b0;
        take_data  = 1'b0;
        wdog_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_start) begin
                    latch_req  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mreq_n) begin
                    state_next = IDLE;
                end else if (cpu_next) begin
                    if (!cpu_rnw) begin
                        state_next = HOLD;
                    end else if (cpu_strobe) begin
                        take_data  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        state_next = RDWAIT;
                    end
                end else if (wdog_hit) begin
                    wdog_fire  = 1'b1;
                    state_next = HOLD;
                end
            end
            RDWAIT: begin
                if (mreq_n) begin
                    state_next = IDLE;
                end else if (cpu_strobe) begin
                    take_data  = 1'b1;
                    state_next = HOLD;
                end else if (wdog_hit) begin
                    wdog_fire  = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (mreq_n) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // 'armed' blocks a MREQ that was already low when reset released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wdog_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_next;
            wdog_cnt <= stalled ? wdog_cnt + 1'b1 : '0;
            if (mreq_n) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rnw   <= 1'b1;
            cpu_addr  <= '0;
            cpu_wdata <= '0;
        end else if (latch_req) begin
            cpu_rnw   <= !rd_n;
            cpu_addr  <= za;
            cpu_wdata <= zd_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zd_out   <= 8'hFF;
            zd_ena   <= 1'b0;
            wdog_err <= 1'b0;
        end else begin
            if (take_data) begin
                zd_out <= dram_rdata;
                zd_ena <= 1'b1;
            end else if (wdog_fire && cpu_rnw) begin
                zd_out <= 8'hFF;
                zd_ena <= 1'b1;
            end else if (state_next == IDLE) begin
                zd_ena <= 1'b0;
            end
            if (wdog_fire) begin
                wdog_err <= 1'b1;
            end
        end
    end

    // Speed changes only at the refresh T3 edge, never in the middle of an access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turbo <= 2'b00;
        end else if (zpos && !rfsh_n && !mreq_n) begin
            turbo <= turbo_req;
        end
    end

endmodule

// File: tb/tb_zmem_stall.sv
// Directed self-checking bench for zmem_stall: read, write, turbo, watchdog,
// abort, reset and same-clock completion cases with hand-computed expectations.
module tb_zmem_stall;

    logic        clk;
    logic        rst;
    logic        zpos;
    logic        zneg;
    logic        mreq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic [15:0] za;
    logic [7:0]  zd_in;
    logic [1:0]  turbo_req;
    logic [1:0]  turbo;
    logic        cpu_req;
    logic        cpu_rnw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_next;
    logic        cpu_strobe;
    logic [7:0]  dram_rdata;
    logic [7:0]  zd_out;
    logic        zd_ena;
    logic        cpu_stall;
    logic        wdog_err;

    int checks;
    int errors;
    int stall_cnt;
    int req_cnt;
    int req_rise;
    logic prev_req;

    zmem_stall #(.WDOG_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .zpos       (zpos),
        .zneg       (zneg),
        .mreq_n     (mreq_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .rfsh_n     (rfsh_n),
        .za         (za),
        .zd_in      (zd_in),
        .turbo_req  (turbo_req),
        .turbo      (turbo),
        .cpu_req    (cpu_req),
        .cpu_rnw    (cpu_rnw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_next   (cpu_next),
        .cpu_strobe (cpu_strobe),
        .dram_rdata (dram_rdata),
        .zd_out     (zd_out),
        .zd_ena     (zd_ena),
        .cpu_stall  (cpu_stall),
        .wdog_err   (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " cpu_req"},   {15'd0, cpu_req},   16'h0000);
        check({tag, " cpu_stall"}, {15'd0, cpu_stall}, 16'h0000);
        check({tag, " cpu_rnw"},   {15'd0, cpu_rnw},   16'h0001);
        check({tag, " cpu_addr"},  cpu_addr,           16'h0000);
        check({tag, " cpu_wdata"}, {8'd0, cpu_wdata},  16'h0000);
        check({tag, " zd_out"},    {8'd0, zd_out},     16'h00FF);
        check({tag, " zd_ena"},    {15'd0, zd_ena},    16'h0000);
        check({tag, " turbo"},     {14'd0, turbo},     16'h0000);
        check({tag, " wdog_err"},  {15'd0, wdog_err},  16'h0000);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        zpos       = 1'b0;
        zneg       = 1'b0;
        mreq_n     = 1'b1;
        rd_n       = 1'b1;
        wr_n       = 1'b1;
        rfsh_n     = 1'b1;
        za         = 16'h0000;
        zd_in      = 8'h00;
        turbo_req  = 2'b00;
        cpu_next   = 1'b0;
        cpu_strobe = 1'b0;
        dram_rdata = 8'h00;
        #12;
        check_reset_values("reset");
        step();
        rst = 1'b0;
        step();
        step();

        // Read: cpu_next seen on the 5th edge, strobe two edges later.
        mreq_n     = 1'b0;
        rd_n       = 1'b0;
        za         = 16'h4000;
        dram_rdata = 8'hA5;
        stall_cnt  = 0;
        req_cnt    = 0;
        req_rise   = 0;
        prev_req   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cpu_next   = (i == 4);
            cpu_strobe = (i == 6);
            step();
            stall_cnt += int'(cpu_stall);
            req_cnt   += int'(cpu_req);
            if (cpu_req && !prev_req) req_rise++;
            prev_req = cpu_req;
            if (i == 0) begin
                check("read first req",   {15'd0, cpu_req},   16'h0001);
                check("read first stall", {15'd0, cpu_stall}, 16'h0001);
            end
            if (i == 5) check("read zd_ena before strobe", {15'd0, zd_ena}, 16'h0000);
            if (i == 6) begin
                check("read zd_ena after strobe", {15'd0, zd_ena},    16'h0001);
                check("read stall after strobe",  {15'd0, cpu_stall}, 16'h0000);
            end
        end
        cpu_next   = 1'b0;
        cpu_strobe = 1'b0;
        check("read cpu_addr",    cpu_addr,          16'h4000);
        check("read cpu_rnw",     {15'd0, cpu_rnw},  16'h0001);
        check("read stall clks",  16'(stall_cnt),    16'd6);
        check("read req clks",    16'(req_cnt),      16'd4);
        check("read req pulses",  16'(req_rise),     16'd1);
        check("read zd_out",      {8'd0, zd_out},    16'h00A5);
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        step();
        check("read end zd_ena",  {15'd0, zd_ena},   16'h0000);
        check("read end zd_out",  {8'd0, zd_out},    16'h00A5);
        step();

        // Write: cpu_next on the third edge of the access.
        mreq_n = 1'b0;
        wr_n   = 1'b0;
        za     = 16'h8001;
        zd_in  = 8'h3C;
        step();
        check("write cpu_wdata", {8'd0, cpu_wdata}, 16'h003C);
        check("write cpu_rnw",   {15'd0, cpu_rnw},  16'h0000);
        check("write cpu_addr",  cpu_addr,          16'h8001);
        step();
        check("write stall in req", {15'd0, cpu_stall}, 16'h0001);
        cpu_next = 1'b1;
        step();
        cpu_next = 1'b0;
        check("write stall after next", {15'd0, cpu_stall}, 16'h0000);
        check("write req after next",   {15'd0, cpu_req},   16'h0000);
        check("write zd_ena",           {15'd0, zd_ena},    16'h0000);
        step();
        check("write no reissue", {15'd0, cpu_req}, 16'h0000);
        mreq_n = 1'b1;
        wr_n   = 1'b1;
        step();

        // Turbo: only zpos during refresh with MREQ low may change speed.
        turbo_req = 2'b10;
        mreq_n    = 1'b0;
        zpos      = 1'b1;
        step();
        zpos = 1'b0;
        check("turbo in M1 mreq", {14'd0, turbo}, 16'h0000);
        mreq_n = 1'b1;
        rfsh_n = 1'b0;
        zpos   = 1'b1;
        step();
        zpos = 1'b0;
        check("turbo rfsh no mreq", {14'd0, turbo}, 16'h0000);
        mreq_n = 1'b0;
        step();
        check("turbo rfsh no zpos", {14'd0, turbo}, 16'h0000);
        zpos = 1'b1;
        step();
        zpos = 1'b0;
        check("turbo refresh zpos",   {14'd0, turbo},     16'h0002);
        check("refresh no stall",     {15'd0, cpu_stall}, 16'h0000);
        turbo_req = 2'b01;
        step();
        check("turbo holds",          {14'd0, turbo},     16'h0002);
        mreq_n = 1'b1;
        rfsh_n = 1'b1;
        step();

        // Watchdog: read never accepted.
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        za     = 16'h1234;
        step();
        stall_cnt = 0;
        for (int i = 0; i < 300 && cpu_stall; i++) begin
            stall_cnt++;
            step();
        end
        check("wdog stall clks", 16'(stall_cnt),     16'd255);
        check("wdog err",        {15'd0, wdog_err},  16'h0001);
        check("wdog zd_out",     {8'd0, zd_out},     16'h00FF);
        check("wdog zd_ena",     {15'd0, zd_ena},    16'h0001);
        check("wdog req",        {15'd0, cpu_req},   16'h0000);
        step();
        check("wdog hold no reissue", {15'd0, cpu_req}, 16'h0000);
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        step();
        check("wdog end zd_ena", {15'd0, zd_ena},   16'h0000);

        // Normal access after the timeout; same-clock next+strobe skips RDWAIT.
        mreq_n     = 1'b0;
        rd_n       = 1'b0;
        za         = 16'h2222;
        dram_rdata = 8'h5A;
        step();
        check("post wdog req", {15'd0, cpu_req}, 16'h0001);
        cpu_next   = 1'b1;
        cpu_strobe = 1'b1;
        step();
        cpu_next   = 1'b0;
        cpu_strobe = 1'b0;
        check("simul zd_out",   {8'd0, zd_out},     16'h005A);
        check("simul zd_ena",   {15'd0, zd_ena},    16'h0001);
        check("simul no stall", {15'd0, cpu_stall}, 16'h0000);
        check("simul addr",     cpu_addr,           16'h2222);
        check("wdog err sticky", {15'd0, wdog_err}, 16'h0001);
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        step();

        // Abort: MREQ rises while the request is pending.
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        za     = 16'h3333;
        step();
        check("abort req up", {15'd0, cpu_req}, 16'h0001);
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        step();
        check("abort req",    {15'd0, cpu_req},   16'h0000);
        check("abort stall",  {15'd0, cpu_stall}, 16'h0000);
        check("abort zd_ena", {15'd0, zd_ena},    16'h0000);
        step();

        // Reset during RDWAIT, then a still-low MREQ must be ignored.
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        za     = 16'h5555;
        step();
        cpu_next = 1'b1;
        step();
        cpu_next = 1'b0;
        check("rdwait stall", {15'd0, cpu_stall}, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async reset");
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no req low mreq", {15'd0, cpu_req}, 16'h0000);
        end
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        step();
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        za     = 16'h6666;
        step();
        check("req after fresh mreq", {15'd0, cpu_req}, 16'h0001);
        check("addr after fresh mreq", cpu_addr,        16'h6666);
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
